// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch sequencer:
//   - ADDR_W / INSTR_W : PC and instruction word widths
//   - PC_INC           : sequential PC step (one 32-bit word)
//   - ALIGN_MASK       : clears PC bits [1:0] on redirect targets
//   - fetch_state_t    : sequencer FSM encoding (RUN, HALTED, FAULT)
//   - fetch_entry_t    : prefetch-queue entry {pc, instr}
//   - align_word()     : forces a byte address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC     = 64'h0000_0000_0000_0004;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   DEPTH-entry synchronous FIFO holding fetched {pc, instr} pairs.
//   Flush empties the queue in one edge and overrides push/pop.
//   Push while full is accepted only together with a pop (count unchanged).
//   The head is read straight out of the storage registers, so it stays stable
//   until the head advances. Storage is cleared on reset so the head reads 0.
// Ports
//   clk        in   clock
//   rst_n      in   synchronous reset, active low
//   flush      in   discard all entries
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   advance the head
//   head       out  oldest entry
//   full       out  DEPTH entries held
//   empty      out  no entries held
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);
  // a push into a full queue only fits when the head leaves on the same edge
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the PC, drives the combinational instruction memory, captures the
//   returned word into a prefetch queue and presents the queue head to decode
//   over a valid/ready handshake. Redirects flush the queue and reload the PC;
//   Halt stops new fetches while queued words drain.
//   Optional bounds check: define IMEM_BOUNDS_CHECK_EN to fault on fetches
//   outside [PC_LO, PC_HI] or misaligned; without it Fault is tied low.
// Ports
//   Clk          in   clock
//   Rst_n        in   synchronous reset, active low
//   ImemAddr     out  fetch address (always the PC)
//   ImemInstr    in   instruction word at ImemAddr, same cycle
//   FetchValid   out  queue head valid
//   FetchReady   in   decode accepts the head this cycle
//   FetchInstr   out  head instruction
//   FetchPC      out  head PC
//   RedirectVld  in   taken branch / jump
//   RedirectPC   in   redirect target, bits [1:0] ignored
//   Halt         in   stop issuing new fetches (level)
//   Busy         out  sequencer running and not halted (registered)
//   Fault        out  sticky bounds fault (registered)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_0000_0038,
  parameter logic [ADDR_W-1:0] PC_LO    = 64'h0000_0000_0000_0038,
  parameter logic [ADDR_W-1:0] PC_HI    = 64'h0000_0000_0000_0068
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic [ADDR_W-1:0]  ImemAddr,
  input  logic [INSTR_W-1:0] ImemInstr,
  output logic               FetchValid,
  input  logic               FetchReady,
  output logic [INSTR_W-1:0] FetchInstr,
  output logic [ADDR_W-1:0]  FetchPC,
  input  logic               RedirectVld,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Halt,
  output logic               Busy,
  output logic               Fault
);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  fetch_state_t      state_r;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_r;
  logic              busy_r;
  logic              pop_s;
  logic              issue_ok_s;
  logic              bounds_bad_s;
  logic              fault_s;
  logic              push_s;
  logic              q_full_s;
  logic              q_empty_s;
  fetch_entry_t      entry_s;
  fetch_entry_t      head_s;

  assign ImemAddr   = pc_r;
  assign FetchValid = ~q_empty_s;
  assign FetchPC    = head_s.pc;
  assign FetchInstr = head_s.instr;
  assign Busy       = busy_r;

  assign pop_s        = FetchValid & FetchReady;
  // redirect has priority over issue: the cycle it arrives nothing is pushed
  assign issue_ok_s   = (state_r == ST_RUN) & ~Halt & ~RedirectVld;
  assign bounds_bad_s = BOUNDS_EN & ((pc_r < PC_LO) | (pc_r > PC_HI) | (pc_r[1:0] != 2'b00));
  assign fault_s      = issue_ok_s & bounds_bad_s;
  assign push_s       = issue_ok_s & ~bounds_bad_s & (~q_full_s | pop_s);
  assign entry_s      = {pc_r, ImemInstr};

  // next-state logic for RUN / HALTED / FAULT
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_RUN: begin
        if (Halt) begin
          state_next = ST_HALTED;
        end else if (fault_s) begin
          state_next = ST_FAULT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!Halt) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_HALTED;
        end
      end
      ST_FAULT: begin
        // the new target is re-checked on the first issue attempt back in RUN
        if (RedirectVld) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_FAULT;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // state register and registered Busy flag
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= ST_RUN;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      busy_r  <= (state_next == ST_RUN);
    end
  end

  // PC: redirect wins over sequential advance; holds when nothing is pushed
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pc_r <= RESET_PC;
    end else if (RedirectVld) begin
      pc_r <= align_word(RedirectPC);
    end else if (push_s) begin
      pc_r <= pc_r + PC_INC;
    end else begin
      pc_r <= pc_r;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  logic fault_r;

  // sticky fault flag, cleared only by leaving FAULT
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= (state_next == ST_FAULT);
    end
  end

  assign Fault = fault_r;
`else
  assign Fault = 1'b0;
`endif

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .flush     (RedirectVld),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (q_full_s),
    .empty     (q_empty_s)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed scenarios followed by random traffic. A transaction-level model
//   (queue of expected {pc, instr}, a model PC and run/halt/fault flags) is
//   advanced by the stimulus process; a separate monitor compares the DUT
//   outputs against the model every cycle and pops on each handshake.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h38;
  localparam logic [63:0] PC_LO    = 64'h38;
  localparam logic [63:0] PC_HI    = 64'h68;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [63:0] ImemAddr;
  logic [31:0] ImemInstr;
  logic        FetchValid;
  logic        FetchReady;
  logic [31:0] FetchInstr;
  logic [63:0] FetchPC;
  logic        RedirectVld;
  logic [63:0] RedirectPC;
  logic        Halt;
  logic        Busy;
  logic        Fault;

  fetch_sequencer #(
    .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_LO(PC_LO), .PC_HI(PC_HI)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ImemAddr(ImemAddr), .ImemInstr(ImemInstr),
    .FetchValid(FetchValid), .FetchReady(FetchReady), .FetchInstr(FetchInstr),
    .FetchPC(FetchPC), .RedirectVld(RedirectVld), .RedirectPC(RedirectPC),
    .Halt(Halt), .Busy(Busy), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // instruction memory model
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h38:  return 32'h8B1F03E9;
      64'h3c:  return 32'hB2048D29;
      64'h40:  return 32'hD37F3129;
      64'h5c:  return 32'hB237BD29;
      64'h68:  return 32'hF84283EA;
      default: return a[31:0] ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb ImemInstr = mem_word(ImemAddr);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];
  logic [63:0] m_pc;
  bit          m_halted, m_faulted, m_busy, m_fault;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares DUT against the model and retires handshaken words
  always @(negedge Clk) begin
    if (mon_en) begin
      check("fetch_valid", 64'(FetchValid), 64'(exp_q.size() != 0));
      if (FetchValid && exp_q.size() != 0) begin
        check("fetch_pc", FetchPC, exp_q[0].pc);
        check("fetch_instr", 64'(FetchInstr), 64'(exp_q[0].instr));
      end
      check("imem_addr", ImemAddr, m_pc);
      check("busy", 64'(Busy), 64'(m_busy));
      check("fault", 64'(Fault), 64'(m_fault));
      if (FetchValid && FetchReady && exp_q.size() != 0) begin
        dlv_pc.push_back(FetchPC);
        dlv_instr.push_back(FetchInstr);
        void'(exp_q.pop_front());
      end
    end
  end

  // drive one cycle of inputs and advance the model across the next edge
  task automatic cycle(input logic rn, input logic rdy, input logic rv,
                       input logic [63:0] rp, input logic hl);
    bit   pop, do_push, do_fault, running;
    exp_t e;
    Rst_n = rn; FetchReady = rdy; RedirectVld = rv; RedirectPC = rp; Halt = hl;
    pop = (exp_q.size() != 0) && rdy;
    do_push = 1'b0; do_fault = 1'b0;
    running = !m_halted && !m_faulted;
    if (rn && running && !hl && !rv) begin
      if (BOUNDS && (m_pc < PC_LO || m_pc > PC_HI || m_pc[1:0] != 2'b00)) do_fault = 1'b1;
      else if (exp_q.size() < DEPTH || pop) do_push = 1'b1;
    end
    e.pc = m_pc;
    e.instr = mem_word(m_pc);
    @(posedge Clk);
    if (!rn) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_halted = 1'b0; m_faulted = 1'b0; m_busy = 1'b0; m_fault = 1'b0;
      mon_en = 1'b1;
    end else begin
      if (rv) begin
        exp_q.delete();
        m_pc = rp & ~64'h3;
      end else if (do_push) begin
        exp_q.push_back(e);
        m_pc = m_pc + 64'd4;
      end
      if (m_faulted) begin
        if (rv) m_faulted = 1'b0;
      end else if (m_halted) begin
        if (!hl) m_halted = 1'b0;
      end else if (hl) begin
        m_halted = 1'b1;
      end else if (do_fault) begin
        m_faulted = 1'b1;
      end
      m_busy  = !m_halted && !m_faulted;
      m_fault = m_faulted;
    end
    #1;
  endtask

  task automatic run(input int n, input logic rdy, input logic hl);
    for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0, 64'h0, hl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] freeze_pc;
    int          base, n48;
    logic        hl;

    // 1: reset state, then streaming with FetchReady=1
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    check("rst_valid", 64'(FetchValid), 64'h0);
    check("rst_busy", 64'(Busy), 64'h0);
    check("rst_fault", 64'(Fault), 64'h0);
    check("rst_fetch_pc", FetchPC, 64'h0);
    check("rst_fetch_instr", 64'(FetchInstr), 64'h0);
    check("rst_imem_addr", ImemAddr, 64'h38);
    dlv_pc.delete(); dlv_instr.delete();
    run(4, 1'b1, 1'b0);
    check("t1_count", 64'(dlv_pc.size()), 64'd3);
    check("t1_pc0", dlv_pc[0], 64'h38);
    check("t1_in0", 64'(dlv_instr[0]), 64'h8B1F03E9);
    check("t1_pc1", dlv_pc[1], 64'h3c);
    check("t1_in1", 64'(dlv_instr[1]), 64'hB2048D29);
    check("t1_pc2", dlv_pc[2], 64'h40);
    check("t1_in2", 64'(dlv_instr[2]), 64'hD37F3129);

    // 2: back-pressure fills the queue, then release
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    dlv_pc.delete(); dlv_instr.delete();
    run(5, 1'b0, 1'b0);
    check("t2_imem_addr", ImemAddr, 64'h40);
    check("t2_head_pc", FetchPC, 64'h38);
    check("t2_head_instr", 64'(FetchInstr), 64'h8B1F03E9);
    run(3, 1'b1, 1'b0);

    // 3: redirect while head is 0x044
    check("t3_head_pc", FetchPC, 64'h44);
    cycle(1'b1, 1'b1, 1'b1, 64'h5E, 1'b0);
    check("t3_valid_after_redirect", 64'(FetchValid), 64'h0);
    run(3, 1'b1, 1'b0);
    check("t2_count", 64'(dlv_pc.size()), 64'd6);
    check("t2_pc0", dlv_pc[0], 64'h38);
    check("t2_pc1", dlv_pc[1], 64'h3c);
    check("t2_pc2", dlv_pc[2], 64'h40);
    check("t2_pc3", dlv_pc[3], 64'h44);
    check("t3_pc4", dlv_pc[4], 64'h5c);
    check("t3_in4", 64'(dlv_instr[4]), 64'hB237BD29);
    n48 = 0;
    foreach (dlv_pc[i]) if (dlv_pc[i] == 64'h48) n48++;
    check("t3_no_048", 64'(n48), 64'd0);

    // 4: halt with two queued words
    cycle(1'b1, 1'b1, 1'b1, 64'h38, 1'b0);
    run(3, 1'b0, 1'b0);
    freeze_pc = m_pc;
    base = dlv_pc.size();
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    check("t4_busy_halted", 64'(Busy), 64'h0);
    run(3, 1'b1, 1'b1);
    check("t4_drained", 64'(dlv_pc.size() - base), 64'd2);
    check("t4_valid_empty", 64'(FetchValid), 64'h0);
    check("t4_addr_frozen", ImemAddr, freeze_pc);
    check("t4_busy_still", 64'(Busy), 64'h0);
    run(3, 1'b1, 1'b0);
    check("t4_resume_count", 64'(dlv_pc.size() - base), 64'd3);
    check("t4_resume_pc", dlv_pc[base+2], freeze_pc);
    check("t4_busy_run", 64'(Busy), 64'h1);

    // 6: reset mid-stream with full queue and a pending redirect
    run(2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 64'h50, 1'b0);
    check("t6_valid", 64'(FetchValid), 64'h0);
    check("t6_pc", ImemAddr, 64'h38);
    check("t6_fault", 64'(Fault), 64'h0);

`ifdef IMEM_BOUNDS_CHECK_EN
    // 5: run past PC_HI, fault, recover by redirect
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    dlv_pc.delete(); dlv_instr.delete();
    run(16, 1'b1, 1'b0);
    check("t5_count", 64'(dlv_pc.size()), 64'd13);
    check("t5_last_pc", dlv_pc[dlv_pc.size()-1], 64'h68);
    check("t5_last_instr", 64'(dlv_instr[dlv_instr.size()-1]), 64'hF84283EA);
    check("t5_fault", 64'(Fault), 64'h1);
    check("t5_pc_hold", ImemAddr, 64'h6c);
    cycle(1'b1, 1'b1, 1'b1, 64'h38, 1'b0);
    run(2, 1'b1, 1'b0);
    check("t5_fault_clr", 64'(Fault), 64'h0);
    check("t5_resume_pc", dlv_pc[dlv_pc.size()-1], 64'h38);
`endif

    // random traffic
    hl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) hl = ~hl;
      if ($urandom_range(0, 199) == 0) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'h40, hl);
      end else begin
        cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
              64'h30 + 64'($urandom_range(0, 64)), hl);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
